idct4_pipe: RTL

- Parametrised, fully pipelined 4-point inverse DCT. Takes one 4-sample coefficient vector per accepted cycle and produces all four outputs together.
- Uses the standard integer matrix (64, 83, 36) with an even/odd butterfly, per-vector selectable rounding shift, and a valid/ready handshake with backpressure.
- Used for both the row pass and the column pass of the 2-D inverse transform.

---
 rtl/idct4_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/idct4_pipe.sv
// Fully pipelined 4-point inverse DCT (64/83/36 butterfly), 3 register stages, valid/ready.
// Define IDCT_SAT_EN to clip each lane to OUT_W and drive sat_flag; otherwise lanes wrap.
module idct4_pipe_lane #(
  parameter int ACC_W  = 25,
  parameter int OUT_W  = 16,
  parameter int SHIFT0 = 7,
  parameter int SHIFT1 = 12
) (
  input  logic signed [ACC_W-1:0] i_y,
  input  logic                    i_sel,
  output logic [OUT_W-1:0]        o_r,
  output logic                    o_clip
);
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] H0 = {{(RW-1){1'b0}}, 1'b1} << (SHIFT0-1);
  localparam logic signed [RW-1:0] H1 = {{(RW-1){1'b0}}, 1'b1} << (SHIFT1-1);

  logic signed [RW-1:0] w_ye, w_s0, w_s1, w_r;

  // one guard bit so the rounding add cannot overflow
  assign w_ye = {i_y[ACC_W-1], i_y};
  assign w_s0 = w_ye + H0;
  assign w_s1 = w_ye + H1;
  assign w_r  = i_sel ? (w_s1 >>> SHIFT1) : (w_s0 >>> SHIFT0);

`ifdef IDCT_SAT_EN
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic w_hi, w_lo;
  assign w_hi   = w_r > MAXV;
  assign w_lo   = w_r < MINV;
  assign o_clip = w_hi | w_lo;
  assign o_r    = w_hi ? MAXV[OUT_W-1:0] : (w_lo ? MINV[OUT_W-1:0] : w_r[OUT_W-1:0]);
`else
  logic w_unused;
  assign w_unused = ^w_r[RW-1:OUT_W];
  assign o_clip   = 1'b0;
  assign o_r      = w_r[OUT_W-1:0];
`endif
endmodule

module idct4_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT0 = 7,
  parameter int SHIFT1 = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_shift_sel,
  input  logic [4*IN_W-1:0]    d_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*OUT_W-1:0]   d_out,
  output logic                 sat_flag
);
  localparam int ACC_W = IN_W + 9;
  localparam logic signed [ACC_W-1:0] C64 = ACC_W'(64);
  localparam logic signed [ACC_W-1:0] C83 = ACC_W'(83);
  localparam logic signed [ACC_W-1:0] C36 = ACC_W'(36);

  logic                    w_adv, w_xfer;
  logic signed [ACC_W-1:0] w_sx [4];
  logic signed [ACC_W-1:0] w_e0, w_e1, w_o0, w_o1;
  logic [3:0][OUT_W-1:0]   w_r;
  logic [3:0]              w_clip;

  logic [2:0]              r_vld_pipe;
  logic [1:0]              r_sel_pipe;
  logic signed [ACC_W-1:0] r_p0, r_p2, r_p1a, r_p1b, r_p3a, r_p3b;
  logic signed [ACC_W-1:0] r_y [4];
  logic [4*OUT_W-1:0]      r_dout;
  logic                    r_sat;

  // the whole pipe stalls as one unit only when the output slot is full and blocked
  assign w_adv    = out_ready | ~r_vld_pipe[2];
  assign w_xfer   = in_valid & w_adv;
  assign in_ready = w_adv;

  for (genvar g = 0; g < 4; g++) begin : g_ext
    assign w_sx[g] = {{(ACC_W-IN_W){d_in[g*IN_W+IN_W-1]}}, d_in[g*IN_W +: IN_W]};
  end

  assign w_e0 = r_p0 + r_p2;
  assign w_e1 = r_p0 - r_p2;
  assign w_o0 = r_p1a + r_p3b;
  assign w_o1 = r_p1b - r_p3a;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    idct4_pipe_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT0(SHIFT0), .SHIFT1(SHIFT1)) u_lane (
      .i_y    (r_y[g]),
      .i_sel  (r_sel_pipe[1]),
      .o_r    (w_r[g]),
      .o_clip (w_clip[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_sel_pipe <= '0;
      r_p0  <= '0; r_p2  <= '0;
      r_p1a <= '0; r_p1b <= '0;
      r_p3a <= '0; r_p3b <= '0;
      for (int i = 0; i < 4; i++) r_y[i] <= '0;
      r_dout <= '0;
      r_sat  <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[1:0], w_xfer};
      r_sel_pipe <= {r_sel_pipe[0], in_shift_sel};
      r_p0  <= w_sx[0] * C64;
      r_p2  <= w_sx[2] * C64;
      r_p1a <= w_sx[1] * C83;
      r_p1b <= w_sx[1] * C36;
      r_p3a <= w_sx[3] * C83;
      r_p3b <= w_sx[3] * C36;
      r_y[0] <= w_e0 + w_o0;
      r_y[1] <= w_e1 + w_o1;
      r_y[2] <= w_e1 - w_o1;
      r_y[3] <= w_e0 - w_o0;
      r_dout <= w_r;
      r_sat  <= r_vld_pipe[1] & (|w_clip);
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign d_out     = r_dout;
  assign sat_flag  = r_sat;
endmodule
